// File: rtl/pkg_control.sv
// Shared definitions for the CU control scheduler: the state encoding and
// the default values of the top-level parameters.
package pkg_control;

  localparam int DEF_NUM_CUS         = 4;
  localparam int DEF_STAGGER_CYCLES  = 2;
  localparam int DEF_WATCHDOG_CYCLES = 1048576;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_SETUP = 3'd2,
    RUN        = 3'd3,
    DONE       = 3'd4,
    TIMEOUT    = 3'd5
  } cu_scheduler_state;

endpackage

// File: rtl/cu_control_watchdog.sv
// No-progress watchdog for the CU scheduler. Counts cycles while enabled,
// restarts on any progress, and flags expiry on the cycle whose edge would
// complete WATCHDOG_CYCLES cycles without progress.
module cu_control_watchdog
  import pkg_control::*;
#(
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic count_en_i,
  input  logic progress_i,
  output logic expired_o
);

  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WATCHDOG_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart outside the watched states or on progress, else climb to the limit
  always_comb begin
    count_d = count_q;
    if (!count_en_i || progress_i) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = count_en_i && !progress_i && (count_q == LIMIT);

endmodule

// File: rtl/cu_control_scheduler.sv
// CU control scheduler: launches the enabled compute units one after another
// with a fixed stagger, then gathers their setup and done indications into
// single setup/done signals for the kernel control chain.
// Optional no-progress watchdog is built when CU_SCHEDULER_WATCHDOG_EN is
// defined; otherwise TIMEOUT is unreachable and timeout_out stays low.
module cu_control_scheduler
  import pkg_control::*;
#(
  parameter int NUM_CUS         = DEF_NUM_CUS,
  parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic               ap_clk,
  input  logic               areset_n,
  input  logic               start_in,
  input  logic [NUM_CUS-1:0] cu_enable_mask,
  input  logic [NUM_CUS-1:0] cu_setup_done,
  input  logic [NUM_CUS-1:0] cu_done,
  output logic [NUM_CUS-1:0] cu_start,
  output logic               setup_out,
  output logic               done_out,
  output logic               busy,
  output logic               timeout_out
);

  // Stagger counter holds STAGGER_CYCLES-1 down to 0; zero means "start the next CU now".
  localparam int STW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [STW-1:0] STAGGER_RELOAD = STW'(STAGGER_CYCLES - 1);

  cu_scheduler_state  state_q;
  logic [NUM_CUS-1:0] mask_q;
  logic [NUM_CUS-1:0] cu_start_q;
  logic [NUM_CUS-1:0] setup_latch_q;
  logic [NUM_CUS-1:0] done_latch_q;
  logic [STW-1:0]     stagger_q;
  logic               setup_q;
  logic               done_q;
  logic               busy_q;
  logic               timeout_q;

  logic [NUM_CUS-1:0] pending;
  logic [NUM_CUS-1:0] next_onehot;
  logic               capture_en;
  logic               go_idle;
  logic               wd_expired;

  // Launch bookkeeping and the common "drop back to IDLE" condition
  always_comb begin
    pending     = mask_q & ~cu_start_q;
    next_onehot = pending & (~pending + NUM_CUS'(1));
    capture_en  = (state_q == LAUNCH) || (state_q == WAIT_SETUP) || (state_q == RUN);
    go_idle     = !start_in && (state_q != IDLE);
  end

`ifdef CU_SCHEDULER_WATCHDOG_EN
  logic count_en;
  logic progress;

  // Progress is any enabled CU reporting setup or done for the first time
  always_comb begin
    count_en = (state_q == WAIT_SETUP) || (state_q == RUN);
    progress = |(((cu_setup_done & ~setup_latch_q) | (cu_done & ~done_latch_q)) & mask_q);
  end

  cu_control_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk_i      (ap_clk),
    .rst_ni     (areset_n),
    .count_en_i (count_en),
    .progress_i (progress),
    .expired_o  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Sequencer: state, latches and all registered outputs advance together
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      cu_start_q    <= '0;
      setup_latch_q <= '0;
      done_latch_q  <= '0;
      stagger_q     <= '0;
      setup_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (go_idle) begin
      // Abort, or release from DONE/TIMEOUT: everything returns to its idle value.
      state_q       <= IDLE;
      mask_q        <= '0;
      cu_start_q    <= '0;
      setup_latch_q <= '0;
      done_latch_q  <= '0;
      stagger_q     <= '0;
      setup_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // Sticky capture; a done arriving before its setup is kept as well.
      if (capture_en) begin
        setup_latch_q <= setup_latch_q | (cu_setup_done & mask_q);
        done_latch_q  <= done_latch_q | (cu_done & mask_q);
      end
      case (state_q)
        IDLE: begin
          if (start_in) begin
            mask_q    <= cu_enable_mask;
            busy_q    <= 1'b1;
            stagger_q <= '0;
            if (|cu_enable_mask) begin
              state_q <= LAUNCH;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (|pending) begin
            if (stagger_q == '0) begin
              cu_start_q <= cu_start_q | next_onehot;
              stagger_q  <= STAGGER_RELOAD;
            end else begin
              stagger_q <= stagger_q - STW'(1);
            end
          end else begin
            state_q <= WAIT_SETUP;
          end
        end
        WAIT_SETUP: begin
          if (setup_latch_q == mask_q) begin
            state_q <= RUN;
            setup_q <= 1'b1;
          end else if (wd_expired) begin
            state_q    <= TIMEOUT;
            cu_start_q <= '0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
          end
        end
        RUN: begin
          if (done_latch_q == mask_q) begin
            state_q    <= DONE;
            cu_start_q <= '0;
            done_q     <= 1'b1;
          end else if (wd_expired) begin
            state_q    <= TIMEOUT;
            cu_start_q <= '0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
          end
        end
        DONE, TIMEOUT: begin
          // Held until start_in drops.
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cu_start    = cu_start_q;
  assign setup_out   = setup_q;
  assign done_out    = done_q;
  assign busy        = busy_q;
  assign timeout_out = timeout_q;

endmodule
